// File: rtl/sram_march_bist_if.sv
// SRAM single-port bus between the BIST initiator and the macro.
// master drives control/data, slave returns dout0.
interface sram_march_bist_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
);
  logic                  csb0;
  logic                  web0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;

  modport master (
    output csb0,
    output web0,
    output addr0,
    output din0,
    input  dout0
  );

  modport slave (
    input  csb0,
    input  web0,
    input  addr0,
    input  din0,
    output dout0
  );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for a single-port SRAM macro.
// One op per cycle, reads checked two edges after issue.
module sram_march_bist #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [2:0]            fail_elem,
  sram_march_bist_if.master     sram
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M1    = 4'd2;
  localparam logic [3:0] S_M2    = 4'd3;
  localparam logic [3:0] S_M3    = 4'd4;
  localparam logic [3:0] S_M4    = 4'd5;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BG_Z   = '0;
  localparam logic [DATA_WIDTH-1:0] BG_O   = '1;

  logic [3:0]            state, n_state;
  logic [ADDR_WIDTH-1:0] addr_q, n_addr;
  logic                  ph_q, n_ph;
  logic                  drain_q, n_drain;

  logic                  accept;
  logic                  is_rw, rw_up, at_end;
  logic [3:0]            rw_next;
  logic [ADDR_WIDTH-1:0] rw_first;

  logic                  n_act, n_rw, n_rd, n_wr;
  logic [DATA_WIDTH-1:0] n_wdata, n_exp;
  logic [2:0]            n_elem;

  logic                  p1_v, p2_v;
  logic [DATA_WIDTH-1:0] p1_exp, p2_exp;
  logic [ADDR_WIDTH-1:0] p1_addr, p2_addr;
  logic [2:0]            p1_elem, p2_elem;
  logic                  miscmp;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign is_rw    = (state >= S_M1) && (state <= S_M4);
  assign rw_up    = (state == S_M1) || (state == S_M2);
  assign at_end   = rw_up ? (addr_q == A_LAST) : (addr_q == A_ZERO);
  assign rw_next  = state + 4'd1;
  assign rw_first = (rw_next == S_M3 || rw_next == S_M4) ? A_LAST : A_ZERO;

  // Sequencer: (state, addr, phase) names the op driven after this edge.
  always_comb begin
    n_state = state;
    n_addr  = addr_q;
    n_ph    = ph_q;
    n_drain = drain_q;
    unique case (1'b1)
      accept: begin
        n_state = S_M0;
        n_addr  = A_ZERO;
        n_ph    = 1'b0;
        n_drain = 1'b0;
      end
      (state == S_M0): begin
        if (addr_q == A_LAST) begin
          n_state = S_M1;
          n_addr  = A_ZERO;
        end else begin
          n_addr = addr_q + A_ONE;
        end
      end
      is_rw: begin
        if (!ph_q) begin
          n_ph = 1'b1;
        end else begin
          n_ph = 1'b0;
          if (at_end) begin
            n_state = rw_next;
            n_addr  = rw_first;
          end else if (rw_up) begin
            n_addr = addr_q + A_ONE;
          end else begin
            n_addr = addr_q - A_ONE;
          end
        end
      end
      (state == S_M5): begin
        if (addr_q == A_LAST) begin
          n_state = S_DRAIN;
          n_addr  = A_ZERO;
          n_drain = 1'b0;
        end else begin
          n_addr = addr_q + A_ONE;
        end
      end
      (state == S_DRAIN): begin
        if (drain_q) begin
          n_state = S_DONE;
          n_drain = 1'b0;
        end else begin
          n_drain = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    n_act   = (n_state >= S_M0) && (n_state <= S_M5);
    n_rw    = (n_state >= S_M1) && (n_state <= S_M4);
    n_rd    = (n_rw && !n_ph) || (n_state == S_M5);
    n_wr    = (n_state == S_M0) || (n_rw && n_ph);
    n_wdata = (n_state == S_M1 || n_state == S_M3) ? BG_O : BG_Z;
    n_exp   = (n_state == S_M2 || n_state == S_M4) ? BG_O : BG_Z;
    n_elem  = 3'(n_state - S_M0);
  end

  assign miscmp = p2_v && (sram.dout0 != p2_exp);

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state      <= S_IDLE;
      addr_q     <= A_ZERO;
      ph_q       <= 1'b0;
      drain_q    <= 1'b0;
      sram.csb0  <= 1'b1;
      sram.web0  <= 1'b1;
      sram.addr0 <= A_ZERO;
      sram.din0  <= BG_Z;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= 8'd0;
      fail_addr  <= A_ZERO;
      fail_data  <= BG_Z;
      fail_elem  <= 3'd0;
      p1_v       <= 1'b0;
      p2_v       <= 1'b0;
      p1_exp     <= BG_Z;
      p2_exp     <= BG_Z;
      p1_addr    <= A_ZERO;
      p2_addr    <= A_ZERO;
      p1_elem    <= 3'd0;
      p2_elem    <= 3'd0;
    end else begin
      state      <= n_state;
      addr_q     <= n_addr;
      ph_q       <= n_ph;
      drain_q    <= n_drain;
      sram.csb0  <= !n_act;
      sram.web0  <= !n_wr;
      sram.addr0 <= n_act ? n_addr : A_ZERO;
      sram.din0  <= n_wr ? n_wdata : BG_Z;
      busy       <= n_act || (n_state == S_DRAIN);
      done       <= (n_state == S_DONE);
      p1_v       <= n_rd;
      p1_exp     <= n_exp;
      p1_addr    <= n_addr;
      p1_elem    <= n_elem;
      p2_v       <= p1_v && !accept;
      p2_exp     <= p1_exp;
      p2_addr    <= p1_addr;
      p2_elem    <= p1_elem;
      if (accept) begin
        pass       <= 1'b0;
        fail_count <= 8'd0;
        fail_addr  <= A_ZERO;
        fail_data  <= BG_Z;
        fail_elem  <= 3'd0;
      end else begin
        if (miscmp) begin
          if (fail_count != 8'hFF) begin
            fail_count <= fail_count + 8'd1;
          end
          if (fail_count == 8'd0) begin
            fail_addr <= p2_addr;
            fail_data <= sram.dout0;
            fail_elem <= p2_elem;
          end
        end
        if (state == S_DRAIN && n_state == S_DONE) begin
          pass <= (fail_count == 8'd0) && !miscmp;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: faulty SRAM model plus a March C- op-list
// reference that predicts bus activity and fail status.
module tb_sram_march_bist;

  localparam int N    = 16;
  localparam int NOPS = 10 * N;

  logic       clk0;
  logic       rst0;
  logic       start;
  logic       busy, done, pass;
  logic [7:0] fail_count;
  logic [3:0] fail_addr;
  logic [1:0] fail_data;
  logic [2:0] fail_elem;

  sram_march_bist_if #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) bus ();

  sram_march_bist #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .fail_elem  (fail_elem),
    .sram       (bus)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  int total = 0;
  int bad   = 0;

  // fault: 0 none, 1 stuck bit fb_g of cell fa_g at fv_g, 2 dout fixed 2'b10
  int mode_g = 0;
  int fa_g   = 0;
  int fb_g   = 0;
  int fv_g   = 0;

  function automatic logic [1:0] fault_rd(input logic [3:0] a,
                                          input logic [1:0] v);
    logic [1:0] r;
    r = v;
    if (mode_g == 1 && int'(a) == fa_g) r[fb_g] = fv_g[0];
    else if (mode_g == 2) r = 2'b10;
    return r;
  endfunction

  logic [1:0] mem [N];
  logic [3:0] rd_a;
  logic [1:0] rd_q;

  always @(posedge clk0) begin
    if (!bus.csb0) begin
      if (!bus.web0) begin
        mem[bus.addr0] <= bus.din0;
      end else begin
        rd_a <= bus.addr0;
        rd_q <= mem[bus.addr0];
      end
    end
  end

  always @(negedge clk0) bus.dout0 <= fault_rd(rd_a, rd_q);

  bit         op_we   [NOPS];
  logic [3:0] op_addr [NOPS];
  logic [1:0] op_data [NOPS];
  int         op_elem [NOPS];

  int         e_cnt;
  logic [3:0] e_addr;
  logic [1:0] e_data;
  int         e_elem;
  bit         e_pass;

  task automatic build_ops();
    int k;
    logic [1:0] rv;
    k = 0;
    for (int a = 0; a < N; a++) begin
      op_we[k] = 1; op_addr[k] = 4'(a); op_data[k] = 2'b00; op_elem[k] = 0;
      k++;
    end
    for (int e = 1; e <= 4; e++) begin
      rv = (e == 1 || e == 3) ? 2'b00 : 2'b11;
      for (int j = 0; j < N; j++) begin
        op_we[k] = 0; op_addr[k] = 4'((e < 3) ? j : N - 1 - j);
        op_data[k] = rv; op_elem[k] = e;
        k++;
        op_we[k] = 1; op_addr[k] = op_addr[k-1];
        op_data[k] = ~rv; op_elem[k] = e;
        k++;
      end
    end
    for (int a = 0; a < N; a++) begin
      op_we[k] = 0; op_addr[k] = 4'(a); op_data[k] = 2'b00; op_elem[k] = 5;
      k++;
    end
  endtask

  task automatic model_run();
    logic [1:0] refm [N];
    logic [1:0] got;
    for (int a = 0; a < N; a++) refm[a] = 2'b00;
    e_cnt = 0; e_addr = 0; e_data = 0; e_elem = 0;
    for (int i = 0; i < NOPS; i++) begin
      if (op_we[i]) begin
        refm[op_addr[i]] = op_data[i];
      end else begin
        got = fault_rd(op_addr[i], refm[op_addr[i]]);
        if (got !== op_data[i]) begin
          if (e_cnt == 0) begin
            e_addr = op_addr[i]; e_data = got; e_elem = op_elem[i];
          end
          if (e_cnt < 255) e_cnt++;
        end
      end
    end
    e_pass = (e_cnt == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk0);
    start = 1'b1;
    @(posedge clk0);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_zero_status(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_pass"}, pass, 0);
    chk({pfx, "_cnt"}, fail_count, 0);
    chk({pfx, "_faddr"}, fail_addr, 0);
    chk({pfx, "_fdata"}, fail_data, 0);
    chk({pfx, "_felem"}, fail_elem, 0);
  endtask

  task automatic run_test(input int busy_poke);
    model_run();
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_cnt", fail_count, 0);
    for (int i = 0; i < NOPS; i++) begin
      chk($sformatf("op%0d_ctl", i), {bus.csb0, bus.web0, bus.addr0},
          {1'b0, !op_we[i], op_addr[i]});
      if (op_we[i])
        chk($sformatf("op%0d_din", i), bus.din0, op_data[i]);
      start = (i == busy_poke);
      @(posedge clk0);
      #1;
    end
    start = 1'b0;
    chk("drain0_csb", bus.csb0, 1);
    chk("drain0_busy", busy, 1);
    chk("drain0_done", done, 0);
    @(posedge clk0);
    #1;
    chk("drain1_done", done, 0);
    @(posedge clk0);
    #1;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_pass", pass, e_pass);
    chk("end_cnt", fail_count, e_cnt);
    if (e_cnt != 0) begin
      chk("end_faddr", fail_addr, e_addr);
      chk("end_fdata", fail_data, e_data);
      chk("end_felem", fail_elem, e_elem);
    end
  endtask

  initial begin
    int stop;
    rst0  = 1'b1;
    start = 1'b0;
    build_ops();
    repeat (3) @(posedge clk0);
    #1;
    chk("rst_csb", bus.csb0, 1);
    chk("rst_web", bus.web0, 1);
    chk("rst_addr", bus.addr0, 0);
    chk("rst_din", bus.din0, 0);
    chk_zero_status("rst");
    @(negedge clk0);
    rst0 = 1'b0;

    mode_g = 0;
    run_test(37);
    chk("clean_pass", pass, 1);

    mode_g = 1; fa_g = 5; fb_g = 0; fv_g = 1;
    run_test(-1);
    chk("sa1_cnt", fail_count, 3);
    chk("sa1_faddr", fail_addr, 5);
    chk("sa1_felem", fail_elem, 1);
    chk("sa1_fdata", fail_data, 2'b01);

    mode_g = 2;
    run_test(int'($urandom_range(0, NOPS - 1)));
    chk("fix_cnt", fail_count, 80);
    chk("fix_faddr", fail_addr, 0);
    chk("fix_felem", fail_elem, 1);

    for (int r = 0; r < 4; r++) begin
      mode_g = 1;
      fa_g   = int'($urandom_range(0, N - 1));
      fb_g   = int'($urandom_range(0, 1));
      fv_g   = int'($urandom_range(0, 1));
      run_test(int'($urandom_range(0, NOPS - 1)));
    end

    mode_g = 2;
    stop = 3 * N + int'($urandom_range(0, 2 * N - 1));
    pulse_start();
    for (int i = 0; i < stop; i++) begin
      @(posedge clk0);
      #1;
    end
    rst0 = 1'b1;
    @(posedge clk0);
    #1;
    chk("mrst_csb", bus.csb0, 1);
    chk("mrst_web", bus.web0, 1);
    chk_zero_status("mrst");
    rst0 = 1'b0;
    mode_g = 0;
    run_test(-1);
    chk("post_rst_pass", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
